// File: rtl/guess_pkg.sv
// guess_pkg: shared types for the guess game round sequencer.
// Holds the sequencer state encoding, score width and score helper.
package guess_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    PLAY   = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Scores stick at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/guess_game_ctrl_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks.
// Ports: clk, reset (sync, active-high) in; tick out.
module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: round sequencer above guess_FSM (tick, reset, scores).
// Ports: clk, reset, start, btn[3:0], fsm_win, fsm_lose in;
// fsm_en, fsm_rst, fsm_b[3:0], wins, losses, last_win,
// show_result, game_over out.
module guess_game_ctrl
  import guess_pkg::*;
#(
  parameter int TICK_DIV    = 25_000_000,
  parameter int RESULT_HOLD = 4,
  parameter int ROUNDS      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         btn,
  input  logic               fsm_win,
  input  logic               fsm_lose,
  output logic               fsm_en,
  output logic               fsm_rst,
  output logic [3:0]         fsm_b,
  output logic [SCORE_W-1:0] wins,
  output logic [SCORE_W-1:0] losses,
  output logic               last_win,
  output logic               show_result,
  output logic               game_over
);

  localparam logic [3:0] HOLD_LAST = 4'(RESULT_HOLD - 1);
  localparam logic [3:0] ROUNDS_L  = 4'(ROUNDS);

  state_t     state;
  logic       tick;
  logic [3:0] hold;
  logic [3:0] round_cnt;
  logic [3:0] next_round;
  logic [3:0] sync1;
  logic [3:0] sync2;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Buttons are asynchronous: two flops before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign next_round = round_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      round_cnt <= '0;
      wins      <= '0;
      losses    <= '0;
      last_win  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wins      <= '0;
            losses    <= '0;
            round_cnt <= '0;
            last_win  <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: state <= PLAY;
        PLAY: begin
          // Win wins a tie with lose.
          if (fsm_win) begin
            wins     <= sat_inc(wins);
            last_win <= 1'b1;
            hold     <= '0;
            state    <= RESULT;
          end else if (fsm_lose) begin
            losses   <= sat_inc(losses);
            last_win <= 1'b0;
            hold     <= '0;
            state    <= RESULT;
          end
        end
        RESULT: begin
          if (tick) begin
            if (hold == HOLD_LAST) begin
              round_cnt <= next_round;
              state <= (next_round == ROUNDS_L)
                       ? DONE : CLEAR;
            end else begin
              hold <= hold + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_en      = tick & (state == PLAY);
  assign fsm_rst     = (state == IDLE) | (state == CLEAR);
  assign fsm_b       = (state == PLAY) ? sync2 : 4'b0;
  assign show_result = (state == RESULT);
  assign game_over   = (state == DONE);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: directed bench for guess_game_ctrl.
// Runs with TICK_DIV=4, RESULT_HOLD=2, ROUNDS=3.
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       fsm_win = 1'b0;
  logic       fsm_lose = 1'b0;
  logic       fsm_en;
  logic       fsm_rst;
  logic [3:0] fsm_b;
  logic [3:0] wins;
  logic [3:0] losses;
  logic       last_win;
  logic       show_result;
  logic       game_over;

  int total = 0;
  int passed = 0;
  int ph = 0;

  always #5 clk = ~clk;

  guess_game_ctrl #(
    .TICK_DIV   (4),
    .RESULT_HOLD(2),
    .ROUNDS     (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .btn        (btn),
    .fsm_win    (fsm_win),
    .fsm_lose   (fsm_lose),
    .fsm_en     (fsm_en),
    .fsm_rst    (fsm_rst),
    .fsm_b      (fsm_b),
    .wins       (wins),
    .losses     (losses),
    .last_win   (last_win),
    .show_result(show_result),
    .game_over  (game_over)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  // One clock; ph mirrors the prescaler count.
  task automatic cyc();
    @(posedge clk);
    ph = reset ? 0 : (ph + 1) % 4;
    @(negedge clk);
  endtask

  task automatic wait_result(output int n,
                             output int ticks,
                             output logic bad);
    n = 0;
    ticks = 0;
    bad = 1'b0;
    while (show_result === 1'b1 && n < 40) begin
      if (ph == 3) ticks++;
      if (fsm_en !== 1'b0 || fsm_b !== 4'b0) bad = 1'b1;
      cyc();
      n++;
    end
    chk("result_bound", 8'(n < 40), 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int entry;
    int ens;
    logic bad;

    repeat (3) cyc();
    chk("rst_wins", 8'(wins), 8'd0);
    chk("rst_losses", 8'(losses), 8'd0);
    chk("rst_last_win", 8'(last_win), 8'd0);
    chk("rst_fsm_rst", 8'(fsm_rst), 8'd1);
    chk("rst_fsm_en", 8'(fsm_en), 8'd0);
    chk("rst_fsm_b", 8'(fsm_b), 8'd0);
    chk("rst_show", 8'(show_result), 8'd0);
    chk("rst_over", 8'(game_over), 8'd0);

    // Scenario 1: start, CLEAR, PLAY, tick, buttons
    reset = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("clear_rst", 8'(fsm_rst), 8'd1);
    chk("clear_en", 8'(fsm_en), 8'd0);
    cyc();
    chk("play_rst", 8'(fsm_rst), 8'd0);
    btn = 4'b0101;
    cyc();
    chk("b_lat1", 8'(fsm_b), 8'd0);
    chk("en_tick", 8'(fsm_en), 8'(ph == 3));
    cyc();
    chk("b_lat2", 8'(fsm_b), 8'h5);
    bad = 1'b0;
    ens = 0;
    for (int i = 0; i < 8; i++) begin
      if (fsm_en !== 1'(ph == 3)) bad = 1'b1;
      if (fsm_en === 1'b1) ens++;
      cyc();
    end
    chk("en_phase", 8'(bad), 8'd0);
    chk("en_count", 8'(ens), 8'd2);

    // Scenario 2: win round
    fsm_win = 1'b1;
    cyc();
    fsm_win = 1'b0;
    entry = ph;
    chk("w1_wins", 8'(wins), 8'd1);
    chk("w1_last", 8'(last_win), 8'd1);
    chk("w1_show", 8'(show_result), 8'd1);
    wait_result(n, t, bad);
    chk("w1_len", 8'(n), 8'(8 - entry));
    chk("w1_ticks", 8'(t), 8'd2);
    chk("w1_gate", 8'(bad), 8'd0);
    chk("w1_clear", 8'(fsm_rst), 8'd1);
    chk("w1_show_off", 8'(show_result), 8'd0);
    cyc();
    chk("w1_play", 8'(fsm_rst), 8'd0);
    chk("w1_play_b", 8'(fsm_b), 8'h5);

    // Scenario 3: lose, lose -> DONE
    fsm_lose = 1'b1;
    cyc();
    fsm_lose = 1'b0;
    chk("l2_losses", 8'(losses), 8'd1);
    chk("l2_last", 8'(last_win), 8'd0);
    wait_result(n, t, bad);
    chk("l2_ticks", 8'(t), 8'd2);
    chk("l2_clear", 8'(fsm_rst), 8'd1);
    cyc();
    fsm_lose = 1'b1;
    cyc();
    fsm_lose = 1'b0;
    chk("l3_losses", 8'(losses), 8'd2);
    wait_result(n, t, bad);
    chk("done_over", 8'(game_over), 8'd1);
    chk("done_rst", 8'(fsm_rst), 8'd0);
    chk("done_wins", 8'(wins), 8'd1);
    chk("done_losses", 8'(losses), 8'd2);
    fsm_win = 1'b1;
    cyc();
    fsm_win = 1'b0;
    cyc();
    chk("done_hold_w", 8'(wins), 8'd1);
    chk("done_hold_l", 8'(losses), 8'd2);
    chk("done_hold_o", 8'(game_over), 8'd1);

    // Scenario 6: start in DONE, then in PLAY
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rs_wins", 8'(wins), 8'd0);
    chk("rs_losses", 8'(losses), 8'd0);
    chk("rs_clear", 8'(fsm_rst), 8'd1);
    chk("rs_over", 8'(game_over), 8'd0);
    cyc();
    chk("rs_play", 8'(fsm_rst), 8'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("sp_rst", 8'(fsm_rst), 8'd0);
    chk("sp_show", 8'(show_result), 8'd0);
    chk("sp_over", 8'(game_over), 8'd0);

    // Scenario 4: simultaneous win and lose
    fsm_win = 1'b1;
    fsm_lose = 1'b1;
    cyc();
    fsm_win = 1'b0;
    fsm_lose = 1'b0;
    chk("tie_wins", 8'(wins), 8'd1);
    chk("tie_losses", 8'(losses), 8'd0);
    chk("tie_last", 8'(last_win), 8'd1);
    wait_result(n, t, bad);
    chk("tie_clear", 8'(fsm_rst), 8'd1);
    cyc();
    fsm_win = 1'b1;
    cyc();
    fsm_win = 1'b0;
    chk("g2_wins", 8'(wins), 8'd2);
    wait_result(n, t, bad);
    cyc();
    chk("g2_play", 8'(fsm_rst), 8'd0);

    // Scenario 5: reset mid-PLAY, start held
    reset = 1'b1;
    start = 1'b1;
    cyc();
    chk("mr_wins", 8'(wins), 8'd0);
    chk("mr_fsm_rst", 8'(fsm_rst), 8'd1);
    chk("mr_fsm_en", 8'(fsm_en), 8'd0);
    chk("mr_last", 8'(last_win), 8'd0);
    reset = 1'b0;
    start = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      cyc();
      if (fsm_rst !== 1'b1 || fsm_en !== 1'b0) bad = 1'b1;
    end
    chk("mr_idle", 8'(bad), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
